// File: rtl/tm_association_arb.sv
// tm_association_arb
//   Arbiter/sequencer for the single-port queue association RAM. Two requesters
//   share the RAM: ASA poll lookups (buffered in a small FIFO) and register-bus
//   reads/writes. One RAM access is in flight at a time. When both requesters
//   are waiting, they are served alternately. Reads are supervised by a timeout,
//   and the read data is returned to the requester that owns the access.
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   poll_req/poll_qid            poll strobe and qid, accepted while the FIFO has room
//   poll_ready                   poll FIFO not full
//   poll_ack/_qid/poll_rdata     poll lookup completion (1-cycle pulse)
//   reg_req/reg_wr/reg_addr/
//   reg_wdata                    register-bus request, held until reg_ack
//   reg_ack/reg_rdata            register access completion (rdata 0 on write)
//   ram_rd/ram_wr/ram_addr/
//   ram_wdata                    RAM access strobes (1-cycle) and address/data
//   ram_ack/ram_rdata            RAM read data valid
//   err_poll_drop                poll_req dropped because the FIFO was full
//   err_timeout                  RAM read not acknowledged in time
module tm_association_arb #(
    parameter int unsigned QID_NBITS     = 8,
    parameter int unsigned DATA_NBITS    = 16,
    parameter int unsigned POLL_FIFO_DEP = 4,
    parameter int unsigned TIMEOUT_CYC   = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  poll_req,
    input  logic [QID_NBITS-1:0]  poll_qid,
    output logic                  poll_ready,
    output logic                  poll_ack,
    output logic [QID_NBITS-1:0]  poll_ack_qid,
    output logic [DATA_NBITS-1:0] poll_rdata,
    input  logic                  reg_req,
    input  logic                  reg_wr,
    input  logic [QID_NBITS-1:0]  reg_addr,
    input  logic [DATA_NBITS-1:0] reg_wdata,
    output logic                  reg_ack,
    output logic [DATA_NBITS-1:0] reg_rdata,
    output logic                  ram_rd,
    output logic                  ram_wr,
    output logic [QID_NBITS-1:0]  ram_addr,
    output logic [DATA_NBITS-1:0] ram_wdata,
    input  logic                  ram_ack,
    input  logic [DATA_NBITS-1:0] ram_rdata,
    output logic                  err_poll_drop,
    output logic                  err_timeout
);

    localparam int unsigned PtrW = (POLL_FIFO_DEP > 1) ? $clog2(POLL_FIFO_DEP) : 1;
    localparam int unsigned CntW = $clog2(POLL_FIFO_DEP + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYC + 2);
    // The RAM may answer up to TIMEOUT_CYC cycles after the ram_rd cycle; the
    // counter is 1 in the ram_rd cycle, so one past that is the expiry value.
    localparam logic [ToW-1:0]  ToLimit = ToW'(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] FifoFull = CntW'(POLL_FIFO_DEP);

    typedef enum logic [1:0] {
        StIdle,
        StRdPoll,
        StRdReg,
        StWrReg
    } state_e;

    // Poll FIFO
    logic [QID_NBITS-1:0] fifo_mem_q [POLL_FIFO_DEP];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q, count_d;
    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop, poll_drop;

    // Sequencer state
    state_e          state_q;
    logic            last_grant_poll_q;
    logic [ToW-1:0]  to_cnt_q;

    // Registered outputs
    logic                  poll_ready_q, poll_ack_q, reg_ack_q;
    logic [QID_NBITS-1:0]  poll_ack_qid_q, ram_addr_q;
    logic [DATA_NBITS-1:0] poll_rdata_q, reg_rdata_q, ram_wdata_q;
    logic                  ram_rd_q, ram_wr_q, err_poll_drop_q, err_timeout_q;

    logic                  poll_cand, reg_cand, grant_poll, grant_reg;
    logic                  in_rd, rd_done, rd_timeout;
    logic [DATA_NBITS-1:0] rd_data;

    always_comb begin
        fifo_full  = (count_q == FifoFull);
        fifo_empty = (count_q == '0);

        poll_cand = !fifo_empty;
        // A reg request still high in its own ack cycle is the one just served.
        reg_cand  = reg_req && !reg_ack_q;

        grant_poll = (state_q == StIdle) && poll_cand && (!reg_cand || !last_grant_poll_q);
        grant_reg  = (state_q == StIdle) && reg_cand && !grant_poll;

        fifo_pop  = grant_poll;
        fifo_push = poll_req && (!fifo_full || fifo_pop);
        poll_drop = poll_req && fifo_full && !fifo_pop;

        count_d = count_q;
        if (fifo_push && !fifo_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!fifo_push && fifo_pop) begin
            count_d = count_q - CntW'(1);
        end

        in_rd      = (state_q == StRdPoll) || (state_q == StRdReg);
        // ram_ack coinciding with our own ram_rd strobe cannot belong to it.
        rd_done    = in_rd && ram_ack && !ram_rd_q;
        rd_timeout = in_rd && !rd_done && (to_cnt_q == ToLimit);
        rd_data    = rd_done ? ram_rdata : '0;
    end

    // FIFO storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q] <= poll_qid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q           <= StIdle;
            last_grant_poll_q <= 1'b0;
            to_cnt_q          <= '0;
            poll_ready_q      <= 1'b0;
            poll_ack_q        <= 1'b0;
            poll_ack_qid_q    <= '0;
            poll_rdata_q      <= '0;
            reg_ack_q         <= 1'b0;
            reg_rdata_q       <= '0;
            ram_rd_q          <= 1'b0;
            ram_wr_q          <= 1'b0;
            ram_addr_q        <= '0;
            ram_wdata_q       <= '0;
            err_poll_drop_q   <= 1'b0;
            err_timeout_q     <= 1'b0;
        end else begin
            ram_rd_q        <= 1'b0;
            ram_wr_q        <= 1'b0;
            poll_ack_q      <= 1'b0;
            reg_ack_q       <= 1'b0;
            err_timeout_q   <= 1'b0;
            err_poll_drop_q <= poll_drop;
            poll_ready_q    <= (count_d != FifoFull);

            unique case (state_q)
                StIdle: begin
                    if (grant_poll) begin
                        ram_rd_q          <= 1'b1;
                        ram_addr_q        <= fifo_mem_q[rd_ptr_q];
                        last_grant_poll_q <= 1'b1;
                        to_cnt_q          <= ToW'(1);
                        state_q           <= StRdPoll;
                    end else if (grant_reg) begin
                        ram_addr_q        <= reg_addr;
                        ram_wdata_q       <= reg_wdata;
                        last_grant_poll_q <= 1'b0;
                        if (reg_wr) begin
                            ram_wr_q <= 1'b1;
                            state_q  <= StWrReg;
                        end else begin
                            ram_rd_q <= 1'b1;
                            to_cnt_q <= ToW'(1);
                            state_q  <= StRdReg;
                        end
                    end
                end
                StWrReg: begin
                    reg_ack_q   <= 1'b1;
                    reg_rdata_q <= '0;
                    state_q     <= StIdle;
                end
                StRdPoll, StRdReg: begin
                    if (rd_done || rd_timeout) begin
                        err_timeout_q <= rd_timeout;
                        to_cnt_q      <= '0;
                        state_q       <= StIdle;
                        if (state_q == StRdPoll) begin
                            poll_ack_q     <= 1'b1;
                            poll_ack_qid_q <= ram_addr_q;
                            poll_rdata_q   <= rd_data;
                        end else begin
                            reg_ack_q   <= 1'b1;
                            reg_rdata_q <= rd_data;
                        end
                    end else begin
                        to_cnt_q <= to_cnt_q + ToW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign poll_ready    = poll_ready_q;
    assign poll_ack      = poll_ack_q;
    assign poll_ack_qid  = poll_ack_qid_q;
    assign poll_rdata    = poll_rdata_q;
    assign reg_ack       = reg_ack_q;
    assign reg_rdata     = reg_rdata_q;
    assign ram_rd        = ram_rd_q;
    assign ram_wr        = ram_wr_q;
    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;
    assign err_poll_drop = err_poll_drop_q;
    assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_tm_association_arb.sv
module tb_tm_association_arb;

    localparam int QW      = 8;
    localparam int DW      = 16;
    localparam int TIMEOUT = 64;
    localparam int KRd     = 0;
    localparam int KWr     = 1;
    localparam int KTo     = 2;

    typedef struct {
        logic [QW-1:0] qid;
        logic [DW-1:0] data;
        int            kind;
    } exp_t;

    logic          clk;
    logic          resetn;
    logic          poll_req;
    logic [QW-1:0] poll_qid;
    logic          poll_ready;
    logic          poll_ack;
    logic [QW-1:0] poll_ack_qid;
    logic [DW-1:0] poll_rdata;
    logic          reg_req;
    logic          reg_wr;
    logic [QW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          reg_ack;
    logic [DW-1:0] reg_rdata;
    logic          ram_rd;
    logic          ram_wr;
    logic [QW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_ack;
    logic [DW-1:0] ram_rdata;
    logic          err_poll_drop;
    logic          err_timeout;

    tm_association_arb #(
        .QID_NBITS    (QW),
        .DATA_NBITS   (DW),
        .POLL_FIFO_DEP(4),
        .TIMEOUT_CYC  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .poll_req     (poll_req),
        .poll_qid     (poll_qid),
        .poll_ready   (poll_ready),
        .poll_ack     (poll_ack),
        .poll_ack_qid (poll_ack_qid),
        .poll_rdata   (poll_rdata),
        .reg_req      (reg_req),
        .reg_wr       (reg_wr),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_ack      (reg_ack),
        .reg_rdata    (reg_rdata),
        .ram_rd       (ram_rd),
        .ram_wr       (ram_wr),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_ack      (ram_ack),
        .ram_rdata    (ram_rdata),
        .err_poll_drop(err_poll_drop),
        .err_timeout  (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RAM model and scoreboard state
    logic [DW-1:0] ram_mem [256];
    exp_t          poll_exp_q [$];
    exp_t          reg_exp_q [$];
    exp_t          mon_e;
    bit            grant_log [$];
    bit            log_en = 0;
    int            ram_lat = 2;
    int            cyc = 0;
    int            late_ack_at = -1;
    bit            pend = 0;
    int            ack_at = 0;
    logic [DW-1:0] pend_data = '0;
    int            last_rd_cyc = 0;
    int            last_wr_cyc = 0;
    int            last_ack_cyc = 0;
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    int            ack_cnt = 0;
    logic [QW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;

    always @(posedge clk) begin
        #1;
        cyc++;
        ram_ack = 1'b0;
        if (pend && ack_at == cyc) begin
            ram_ack      = 1'b1;
            ram_rdata    = pend_data;
            pend         = 0;
            last_ack_cyc = cyc;
        end else if (late_ack_at == cyc) begin
            ram_ack      = 1'b1;
            ram_rdata    = 16'hDEAD;
            last_ack_cyc = cyc;
        end
        if (ram_rd && ram_wr) check_eq("rd_wr_exclusive", 32'(ram_rd & ram_wr), 32'd0);
        if (ram_rd) begin
            rd_cnt++;
            last_rd_cyc = cyc;
            if (pend) check_eq("one_outstanding", 32'(pend), 32'd0);
            if (ram_lat != 0) begin
                pend      = 1;
                ack_at    = cyc + ram_lat;
                pend_data = ram_mem[ram_addr];
            end
            if (log_en) grant_log.push_back(ram_addr >= 8'h40);
        end
        if (ram_wr) begin
            wr_cnt++;
            last_wr_cyc  = cyc;
            last_wr_addr = ram_addr;
            last_wr_data = ram_wdata;
            ram_mem[ram_addr] = ram_wdata;
            if (log_en) grant_log.push_back(1'b1);
        end
        if (err_timeout && !(poll_ack || reg_ack))
            check_eq("timeout_without_ack", 32'(err_timeout), 32'd0);
        if (poll_ack) begin
            ack_cnt++;
            if (poll_exp_q.size() == 0) begin
                check_eq("poll_ack_spurious", 32'(poll_ack), 32'd0);
            end else begin
                mon_e = poll_exp_q.pop_front();
                check_eq("poll_ack_qid", 32'(poll_ack_qid), 32'(mon_e.qid));
                check_eq("poll_rdata", 32'(poll_rdata), 32'(mon_e.data));
                check_eq("poll_timeout_flag", 32'(err_timeout), 32'(mon_e.kind == KTo));
                if (mon_e.kind == KTo)
                    check_eq("poll_timeout_latency", 32'(cyc - last_rd_cyc), 32'(TIMEOUT + 1));
                else
                    check_eq("poll_ack_latency", 32'(cyc - last_ack_cyc), 32'd1);
            end
        end
        if (reg_ack) begin
            ack_cnt++;
            if (reg_exp_q.size() == 0) begin
                check_eq("reg_ack_spurious", 32'(reg_ack), 32'd0);
            end else begin
                mon_e = reg_exp_q.pop_front();
                check_eq("reg_rdata", 32'(reg_rdata), 32'(mon_e.data));
                check_eq("reg_timeout_flag", 32'(err_timeout), 32'(mon_e.kind == KTo));
                if (mon_e.kind == KWr)
                    check_eq("reg_wr_ack_latency", 32'(cyc - last_wr_cyc), 32'd1);
                else if (mon_e.kind == KRd)
                    check_eq("reg_rd_ack_latency", 32'(cyc - last_ack_cyc), 32'd1);
            end
        end
    end

    // Push one poll as soon as the FIFO has room; leaves poll_req high for the caller.
    task automatic poll_push(input logic [QW-1:0] qid, input int kind);
        exp_t e;
        bit   ok = 0;
        poll_req = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (poll_ready) begin
                ok = 1;
                break;
            end
            step();
        end
        check_eq("poll_ready_wait", 32'(ok), 32'd1);
        e.qid  = qid;
        e.data = (kind == KTo) ? '0 : ram_mem[qid];
        e.kind = kind;
        poll_exp_q.push_back(e);
        poll_req = 1'b1;
        poll_qid = qid;
        step();
    endtask

    // Requester behaviour: hold reg_req until reg_ack is seen, drop it the cycle after.
    task automatic reg_access(input logic wr, input logic [QW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                              input int kind);
        exp_t e;
        bit   got = 0;
        e.qid  = addr;
        e.data = exp_rd;
        e.kind = kind;
        reg_exp_q.push_back(e);
        reg_wr    = wr;
        reg_addr  = addr;
        reg_wdata = wdata;
        reg_req   = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (reg_ack) begin
                got = 1;
                break;
            end
        end
        check_eq("reg_ack_seen", 32'(got), 32'd1);
        step();
        reg_req = 1'b0;
    endtask

    task automatic wait_rd(input string tag);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (ram_rd) begin
                ok = 1;
                break;
            end
            step();
        end
        check_eq(tag, 32'(ok), 32'd1);
    endtask

    task automatic drain(input string tag);
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (poll_exp_q.size() == 0 && reg_exp_q.size() == 0) begin
                ok = 1;
                break;
            end
            step();
        end
        check_eq(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, r0, a0;
        for (int i = 0; i < 256; i++) ram_mem[i] = 16'h0100 + 16'(i);
        ram_mem[5] = 16'hA5A5;
        resetn = 1'b0; poll_req = 1'b0; poll_qid = '0;
        reg_req = 1'b0; reg_wr = 1'b0; reg_addr = '0; reg_wdata = '0;
        ram_ack = 1'b0; ram_rdata = '0;

        // Reset state
        step(); step();
        check_eq("rst_poll_ready", 32'(poll_ready), 32'd0);
        check_eq("rst_ram_rd", 32'(ram_rd), 32'd0);
        check_eq("rst_ram_wr", 32'(ram_wr), 32'd0);
        check_eq("rst_acks", 32'({poll_ack, reg_ack, err_poll_drop, err_timeout}), 32'd0);
        resetn = 1'b1;
        step(); step();
        check_eq("post_rst_poll_ready", 32'(poll_ready), 32'd1);

        // 1: single poll
        ram_lat = 2;
        poll_push(8'h05, KRd);
        poll_req = 1'b0;
        wait_rd("t1_rd_seen");
        check_eq("t1_ram_addr", 32'(ram_addr), 32'h05);
        drain("t1_drain");

        // 2: reg write then reg read of the same address
        w0 = wr_cnt; r0 = rd_cnt;
        reg_access(1'b1, 8'h10, 16'h1234, 16'h0000, KWr);
        repeat (4) step();
        check_eq("t2_wr_once", 32'(wr_cnt - w0), 32'd1);
        check_eq("t2_wr_addr", 32'(last_wr_addr), 32'h10);
        check_eq("t2_wr_data", 32'(last_wr_data), 32'h1234);
        reg_access(1'b0, 8'h10, 16'hFFFF, 16'h1234, KRd);
        repeat (4) step();
        check_eq("t2_rd_once", 32'(rd_cnt - r0), 32'd1);
        check_eq("t2_no_reissue_wr", 32'(wr_cnt - w0), 32'd1);
        drain("t2_drain");

        // 3: FIFO full while the RAM stalls, fifth push dropped
        ram_lat = 20;
        poll_push(8'h30, KRd);
        poll_req = 1'b0;
        wait_rd("t3_rd_seen");
        for (int i = 1; i <= 4; i++) poll_push(8'h30 + 8'(i), KRd);
        check_eq("t3_ready_full", 32'(poll_ready), 32'd0);
        poll_qid = 8'h35;
        step();
        poll_req = 1'b0;
        check_eq("t3_drop_pulse", 32'(err_poll_drop), 32'd1);
        step();
        check_eq("t3_drop_one_cycle", 32'(err_poll_drop), 32'd0);
        drain("t3_drain");

        // 4: continuous polls and a held reg requester alternate
        ram_lat = 2;
        grant_log.delete();
        log_en = 1;
        fork
            begin
                for (int i = 0; i < 6; i++) poll_push(8'h20 + 8'(i), KRd);
                poll_req = 1'b0;
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    reg_access(1'b0, 8'h40, 16'h0000, ram_mem[8'h40], KRd);
                    step();
                end
            end
        join
        drain("t4_drain");
        log_en = 0;
        check_eq("t4_grant_count", 32'(grant_log.size() >= 8), 32'd1);
        for (int i = 1; i < 8 && i < grant_log.size(); i++)
            check_eq($sformatf("t4_alternate_%0d", i), 32'(grant_log[i]), 32'(!grant_log[i-1]));

        // 5: RAM never answers, then a late ack, then normal service resumes
        ram_lat = 0;
        poll_push(8'h07, KTo);
        poll_req = 1'b0;
        drain("t5_timeout_drain");
        a0 = ack_cnt;
        late_ack_at = cyc + 2;
        repeat (5) step();
        check_eq("t5_late_ack_ignored", 32'(ack_cnt - a0), 32'd0);
        ram_lat = 2;
        poll_push(8'h08, KRd);
        poll_req = 1'b0;
        drain("t5_next_served");

        // 6: reset while a reg read is outstanding
        ram_lat = 0;
        reg_wr = 1'b0; reg_addr = 8'h11; reg_req = 1'b1;
        wait_rd("t6_rd_seen");
        step(); step();
        resetn = 1'b0;
        #1;
        check_eq("t6_rst_ram_addr", 32'(ram_addr), 32'd0);
        check_eq("t6_rst_rdata", 32'({reg_rdata, poll_rdata}), 32'd0);
        check_eq("t6_rst_qid", 32'(poll_ack_qid), 32'd0);
        check_eq("t6_rst_strobes",
                 32'({ram_rd, ram_wr, poll_ready, poll_ack, reg_ack, err_poll_drop, err_timeout}),
                 32'd0);
        reg_req = 1'b0;
        step(); step();
        resetn = 1'b1;
        a0 = ack_cnt; r0 = rd_cnt;
        step(); step();
        check_eq("t6_ready_after_rst", 32'(poll_ready), 32'd1);
        repeat (10) step();
        check_eq("t6_no_ack", 32'(ack_cnt - a0), 32'd0);
        check_eq("t6_fifo_empty", 32'(rd_cnt - r0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
